// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: samples a target box from the LFSR mapper,
// shows it for a timed window, judges the strike, and tracks score and lives.
module mole_round_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 12_500_000,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         box_in,
  input  logic [3:0]         hit,
  output logic               next_req,
  output logic [1:0]         target,
  output logic               target_valid,
  output logic               result_hit,
  output logic               result_miss,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam int unsigned TIMER_MAX = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_SHOW = 3'd2,
    S_GAP  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t               state, state_d;
  logic [TIMER_W-1:0]   timer, timer_d;
  logic                 strike_hit, strike_miss;
  logic                 next_req_d, target_valid_d, game_over_d;
  logic                 result_hit_d, result_miss_d;
  logic [1:0]           target_d, lives_d;
  logic [SCORE_W-1:0]   score_d;

  // Strike judgement: correct box beats wrong box beats timeout
  always_comb begin
    strike_hit  = 1'b0;
    strike_miss = 1'b0;
    if (state == S_SHOW) begin
      if (hit[target])            strike_hit  = 1'b1;
      else if (hit != 4'b0000)    strike_miss = 1'b1;
      else if (timer == '0)       strike_miss = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_d;
      timer <= timer_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    case (state)
      S_IDLE, S_OVER: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        state_d = S_SHOW;
        timer_d = TIMER_W'(WINDOW_CYCLES - 1);
      end
      S_SHOW: begin
        if (strike_hit || (strike_miss && lives != 2'd1)) begin
          state_d = S_GAP;
          timer_d = TIMER_W'(GAP_CYCLES - 1);
        end else if (strike_miss) begin
          state_d = S_OVER;
          timer_d = '0;
        end else begin
          timer_d = timer - TIMER_W'(1);
        end
      end
      S_GAP: begin
        if (timer == '0) state_d = S_ARM;
        else             timer_d = timer - TIMER_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    target_d       = target;
    score_d        = score;
    lives_d        = lives;
    result_hit_d   = strike_hit;
    result_miss_d  = strike_miss;
    next_req_d     = (state_d == S_ARM);
    target_valid_d = (state_d == S_SHOW);
    game_over_d    = (state_d == S_OVER);
    if ((state == S_IDLE || state == S_OVER) && start) begin
      score_d = '0;
      lives_d = 2'(LIVES);
    end
    if (state == S_ARM) target_d = box_in;
    if (strike_hit && score != SCORE_MAX) score_d = score + SCORE_W'(1);
    if (strike_miss) lives_d = lives - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_req     <= 1'b0;
      target       <= 2'd0;
      target_valid <= 1'b0;
      result_hit   <= 1'b0;
      result_miss  <= 1'b0;
      score        <= '0;
      lives        <= 2'd0;
      game_over    <= 1'b0;
    end else begin
      next_req     <= next_req_d;
      target       <= target_d;
      target_valid <= target_valid_d;
      result_hit   <= result_hit_d;
      result_miss  <= result_miss_d;
      score        <= score_d;
      lives        <= lives_d;
      game_over    <= game_over_d;
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomized round-level bench for mole_round_ctrl; a second instance with a
// 2-bit score shares the stimulus to exercise score saturation.
module tb_mole_round_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned G = 4;
  localparam int unsigned L = 3;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] box_in;
  logic [3:0] hit;
  logic       next_req, target_valid, result_hit, result_miss, game_over;
  logic [1:0] target, lives;
  logic [7:0] score;
  logic       next_req2, target_valid2, result_hit2, result_miss2, game_over2;
  logic [1:0] target2, lives2, score2;

  int checks = 0;
  int failures = 0;

  // Round-level model of the game
  int         m_score, m_lives;
  logic [1:0] m_target;
  bit         m_over;

  always #5 clk = ~clk;

  mole_round_ctrl #(.WINDOW_CYCLES(W), .GAP_CYCLES(G), .LIVES(L), .SCORE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .box_in(box_in), .hit(hit),
    .next_req(next_req), .target(target), .target_valid(target_valid),
    .result_hit(result_hit), .result_miss(result_miss), .score(score),
    .lives(lives), .game_over(game_over));

  mole_round_ctrl #(.WINDOW_CYCLES(W), .GAP_CYCLES(G), .LIVES(L), .SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .box_in(box_in), .hit(hit),
    .next_req(next_req2), .target(target2), .target_valid(target_valid2),
    .result_hit(result_hit2), .result_miss(result_miss2), .score(score2),
    .lives(lives2), .game_over(game_over2));

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b1; hit = 4'hF; box_in = 2'd3;
    step();
    reset = 1'b0; start = 1'b0; hit = 4'h0;
    m_score = 0; m_lives = 0; m_target = 2'd0; m_over = 1'b0;
  endtask

  // In ARM: present the box, then expect it shown as the live target
  task automatic show(input logic [1:0] box);
    box_in = box; hit = 4'($urandom); start = 1'($urandom);
    step();
    hit = 4'h0; start = 1'b0; box_in = 2'($urandom);
    m_target = box;
    checks++;
    if (target !== box) begin failures++; $display("FAIL show_target got=%0d exp=%0d", target, box); end
    checks++;
    if ({target_valid, next_req} !== 2'b10) begin
      failures++; $display("FAIL show_valid got=%b exp=10", {target_valid, next_req});
    end
  endtask

  task automatic do_start(input logic [1:0] box);
    start = 1'b1; hit = 4'($urandom);
    step();
    start = 1'b0; hit = 4'h0;
    m_score = 0; m_lives = L; m_over = 1'b0;
    checks++;
    if ({next_req, target_valid, game_over} !== 3'b100) begin
      failures++; $display("FAIL start_flags got=%b exp=100", {next_req, target_valid, game_over});
    end
    checks++;
    if (score !== 8'd0 || score2 !== 2'd0 || lives !== 2'(L)) begin
      failures++; $display("FAIL start_counts got=%0d/%0d/%0d exp=0/0/%0d", score, score2, lives, L);
    end
    show(box);
  endtask

  // From the first SHOW cycle: strike hv at offset strike (strike>=W means none)
  task automatic play_round(input int strike, input logic [3:0] hv, input logic [1:0] nbox);
    bit exp_hit = 1'b0;
    bit judged = 1'b0;
    int off = 0;
    while (!judged) begin
      hit = (off == strike) ? hv : 4'h0;
      start = 1'($urandom);
      if (hit != 4'h0 || off == int'(W) - 1) begin
        exp_hit = hit[m_target];
        judged = 1'b1;
        step();
      end else begin
        step();
        checks++;
        if ({target_valid, result_hit, result_miss} !== 3'b100) begin
          failures++;
          $display("FAIL window_off%0d got=%b exp=100", off, {target_valid, result_hit, result_miss});
        end
      end
      off++;
    end
    hit = 4'h0; start = 1'b0;
    if (exp_hit) m_score++; else m_lives--;
    m_over = (m_lives == 0);
    checks++;
    if ({result_hit, result_miss, target_valid, next_req} !== {exp_hit, ~exp_hit, 2'b00}) begin
      failures++;
      $display("FAIL judge got=%b exp=%b", {result_hit, result_miss, target_valid, next_req},
               {exp_hit, ~exp_hit, 2'b00});
    end
    checks++;
    if (score !== 8'(sat(m_score, 255)) || score2 !== 2'(sat(m_score, 3))) begin
      failures++;
      $display("FAIL score got=%0d/%0d exp=%0d/%0d", score, score2, sat(m_score, 255), sat(m_score, 3));
    end
    checks++;
    if (lives !== 2'(m_lives) || game_over !== m_over) begin
      failures++;
      $display("FAIL lives got=%0d/%b exp=%0d/%b", lives, game_over, m_lives, m_over);
    end
    if (!m_over) begin
      for (int i = 1; i <= int'(G); i++) begin
        hit = 4'($urandom); start = 1'($urandom);
        step();
        checks++;
        if ({next_req, target_valid, result_hit, result_miss} !== {(i == int'(G)), 3'b000}) begin
          failures++;
          $display("FAIL gap_%0d got=%b exp=%b", i, {next_req, target_valid, result_hit, result_miss},
                   {(i == int'(G)), 3'b000});
        end
      end
      hit = 4'h0; start = 1'b0;
      show(nbox);
    end else begin
      for (int i = 0; i < 3; i++) begin
        hit = 4'($urandom);
        step();
        checks++;
        if ({game_over, next_req, target_valid, lives} !== 5'b10000 || target !== m_target ||
            score !== 8'(sat(m_score, 255))) begin
          failures++;
          $display("FAIL over_hold got=%b t=%0d s=%0d exp=10000 t=%0d s=%0d",
                   {game_over, next_req, target_valid, lives}, target, score, m_target, sat(m_score, 255));
        end
      end
      hit = 4'h0;
    end
  endtask

  function automatic logic [3:0] hit_vec(input logic [1:0] t);
    return 4'($urandom) | (4'b0001 << t);
  endfunction

  function automatic logic [3:0] wrong_vec(input logic [1:0] t);
    logic [3:0] v;
    logic [1:0] o;
    v = 4'($urandom) & ~(4'b0001 << t);
    o = t + 2'd1;
    if (v == 4'h0) v = 4'b0001 << o;
    return v;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({next_req, target, target_valid, result_hit, result_miss, lives, game_over} !== 9'b0 ||
        score !== 8'd0 || score2 !== 2'd0) begin
      failures++;
      $display("FAIL reset got=%b s=%0d exp=0", {next_req, target, target_valid, result_hit,
               result_miss, lives, game_over}, score);
    end
    hit = 4'hF;
    step(); step();
    hit = 4'h0;
    checks++;
    if ({next_req, target_valid, game_over} !== 3'b000) begin
      failures++; $display("FAIL idle_wait got=%b exp=000", {next_req, target_valid, game_over});
    end
  endtask

  task automatic test_start();
    do_start(2'd2);
  endtask

  task automatic test_hit();
    play_round(3, 4'b0100, 2'd2);
  endtask

  task automatic test_timeout();
    play_round(W, 4'h0, 2'd2);
  endtask

  task automatic test_wrong_box();
    play_round(1, 4'b0001, 2'd2);
    play_round(0, 4'b0101, 2'd2);
    play_round(W - 1, 4'b0100, 2'($urandom));
  endtask

  task automatic test_game_over();
    do_reset();
    do_start(2'($urandom));
    play_round($urandom_range(0, W - 1), hit_vec(m_target), 2'($urandom));
    play_round(W, 4'h0, 2'($urandom));
    play_round($urandom_range(0, W - 1), wrong_vec(m_target), 2'($urandom));
    play_round(W, 4'h0, 2'($urandom));
    do_start(2'd1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) play_round($urandom_range(0, W - 1), hit_vec(m_target), 2'($urandom));
  endtask

  task automatic test_reset_mid();
    hit = 4'h0;
    step(); step();
    reset = 1'b1; start = 1'b1; hit = 4'hF;
    step();
    reset = 1'b0; start = 1'b0;
    m_score = 0; m_lives = 0; m_target = 2'd0; m_over = 1'b0;
    checks++;
    if ({next_req, target, target_valid, result_hit, result_miss, lives, game_over} !== 9'b0 ||
        score !== 8'd0 || score2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid got=%b s=%0d exp=0", {next_req, target, target_valid, result_hit,
               result_miss, lives, game_over}, score);
    end
    for (int i = 0; i < 5; i++) begin
      hit = 4'($urandom);
      step();
    end
    hit = 4'h0;
    checks++;
    if ({next_req, target_valid, result_hit, result_miss, game_over} !== 5'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0", {next_req, target_valid, result_hit, result_miss, game_over});
    end
    do_start(2'($urandom));
  endtask

  task automatic test_random();
    for (int g = 0; g < 3; g++) begin
      while (!m_over) begin
        case ($urandom_range(0, 2))
          0: play_round($urandom_range(0, W - 1), hit_vec(m_target), 2'($urandom));
          1: play_round($urandom_range(0, W - 1), wrong_vec(m_target), 2'($urandom));
          default: play_round(W, 4'h0, 2'($urandom));
        endcase
      end
      if (g < 2) do_start(2'($urandom));
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; hit = 4'h0; box_in = 2'd0;
    test_reset();
    test_start();
    test_hit();
    test_timeout();
    test_wrong_box();
    test_game_over();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout_watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
